// File: rtl/pusch_crc_pkg.sv
// Shared types and constants for the PUSCH CRC attachment stage: CRC selection,
// generator polynomials (top term implied) and the attach FSM states.
package pusch_crc_pkg;

  typedef enum logic [1:0] {
    CRC24A = 2'd0,
    CRC24B = 2'd1,
    CRC16  = 2'd2,
    CRC11  = 2'd3
  } crc_sel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TAIL    = 2'd2,
    FLUSH   = 2'd3
  } crc_state_t;

  localparam logic [23:0] POLY_CRC24A = 24'h864CFB;
  localparam logic [23:0] POLY_CRC24B = 24'h800063;
  localparam logic [23:0] POLY_CRC16  = 24'h001021;
  localparam logic [23:0] POLY_CRC11  = 24'h000621;

  function automatic logic [4:0] crc_len(crc_sel_t sel);
    case (sel)
      CRC24A:  crc_len = 5'd24;
      CRC24B:  crc_len = 5'd24;
      CRC16:   crc_len = 5'd16;
      default: crc_len = 5'd11;
    endcase
  endfunction

  function automatic logic [23:0] crc_poly(crc_sel_t sel);
    case (sel)
      CRC24A:  crc_poly = POLY_CRC24A;
      CRC24B:  crc_poly = POLY_CRC24B;
      CRC16:   crc_poly = POLY_CRC16;
      default: crc_poly = POLY_CRC11;
    endcase
  endfunction

endpackage

// File: rtl/pusch_crc_lfsr_step.sv
// Combinational DATA_W-bit parallel CRC update; the CRC is right-aligned in a
// 24-bit register and bits above the active length are masked off.
module pusch_crc_lfsr_step
  import pusch_crc_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [23:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  input  logic [23:0]       poly,
  input  logic [4:0]        crc_len,
  output logic [23:0]       crc_out
);

  logic [23:0] mask;
  logic [23:0] c;
  logic        fb;

  // data[DATA_W-1] is the earliest bit, so it is folded in first.
  always_comb begin
    mask = (24'd1 << crc_len) - 24'd1;
    c    = crc_in & mask;
    fb   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      fb = c[crc_len - 5'd1] ^ data[DATA_W-1-i];
      c  = ((c << 1) & mask) ^ (fb ? poly : 24'd0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/pusch_crc_attach.sv
// PUSCH CRC attachment: forwards the transport block unchanged, then appends
// the selected TS 38.212 CRC, DATA_W bits per beat, valid/ready on both sides.
//
// state   | meaning
// IDLE    | waiting for start; length checked here
// PAYLOAD | accepting payload beats, CRC accumulating
// TAIL    | emitting CRC beats MSB first from the left-aligned CRC register
// FLUSH   | waiting for the final beat to be consumed
module pusch_crc_attach
  import pusch_crc_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int LEN_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        crc_sel,
  input  logic [LEN_W-1:0]  tb_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_nbits,
  output logic              out_crc,
  output logic              out_last,
  output logic              busy,
  output logic              len_err
);

  localparam logic [LEN_W-1:0] DW_LEN = LEN_W'(DATA_W);
  localparam logic [5:0]       DW6    = 6'(DATA_W);
  localparam logic [4:0]       DW5    = 5'(DATA_W);
  localparam logic [3:0]       DW4    = 4'(DATA_W);

  crc_state_t        state, state_nxt;
  crc_sel_t          sel_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [5:0]        tail_cnt;
  logic [23:0]       crc_q;
  logic [23:0]       crc_nxt;
  logic [4:0]        crc_l;
  logic [23:0]       poly;
  logic [5:0]        tail_beats;
  logic [3:0]        tail_rem;
  logic [3:0]        last_nbits;

  logic [DATA_W-1:0] out_data_q;
  logic [3:0]        out_nbits_q;
  logic              out_valid_q;
  logic              out_crc_q;
  logic              out_last_q;
  logic              len_err_q;

  logic              len_ok;
  logic              out_free;
  logic              out_fire;
  logic              in_fire;
  logic              tail_fire;
  logic              in_ready_c;

  assign crc_l    = crc_len(sel_q);
  assign poly     = crc_poly(sel_q);
  assign len_ok   = (tb_len != '0) && ((tb_len % DW_LEN) == '0);
  assign out_fire = out_valid_q && out_ready;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    tail_beats = ({1'b0, crc_l} + DW6 - 6'd1) / DW6;
    tail_rem   = 4'(crc_l % DW5);
    last_nbits = (tail_rem == 4'd0) ? DW4 : tail_rem;
  end

  pusch_crc_lfsr_step #(
    .DATA_W (DATA_W)
  ) u_lfsr_step (
    .crc_in  (crc_q),
    .data    (in_data),
    .poly    (poly),
    .crc_len (crc_l),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    in_fire    = 1'b0;
    tail_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (start && len_ok) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        in_ready_c = out_free;
        in_fire    = in_valid && out_free;
        if (in_fire && (beat_cnt == LEN_W'(1))) state_nxt = TAIL;
      end
      TAIL: begin
        tail_fire = out_free;
        if (tail_fire && (tail_cnt == 6'd1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (out_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On the last payload beat the CRC is left-aligned so the tail shifts out from bit 23.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q       <= CRC24A;
      beat_cnt    <= '0;
      tail_cnt    <= '0;
      crc_q       <= '0;
      out_data_q  <= '0;
      out_nbits_q <= '0;
      out_valid_q <= 1'b0;
      out_crc_q   <= 1'b0;
      out_last_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      if (out_fire) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              sel_q    <= crc_sel_t'(crc_sel);
              beat_cnt <= tb_len / DW_LEN;
              crc_q    <= '0;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (in_fire) begin
            out_data_q  <= in_data;
            out_nbits_q <= DW4;
            out_crc_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b1;
            beat_cnt    <= beat_cnt - LEN_W'(1);
            if (beat_cnt == LEN_W'(1)) begin
              crc_q    <= crc_nxt << (5'd24 - crc_l);
              tail_cnt <= tail_beats;
            end else begin
              crc_q <= crc_nxt;
            end
          end
        end
        TAIL: begin
          if (tail_fire) begin
            out_data_q  <= crc_q[23 -: DATA_W];
            out_nbits_q <= (tail_cnt == 6'd1) ? last_nbits : DW4;
            out_crc_q   <= 1'b1;
            out_last_q  <= (tail_cnt == 6'd1);
            out_valid_q <= 1'b1;
            crc_q       <= crc_q << DATA_W;
            tail_cnt    <= tail_cnt - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nbits = out_nbits_q;
  assign out_crc   = out_crc_q;
  assign out_last  = out_last_q;
  assign busy      = (state != IDLE);
  assign len_err   = len_err_q;

endmodule
